writeback_stage: RTL

- MEM/WB pipeline register plus writeback-select logic for the 5-stage pipeline.
- Captures the instruction leaving MEM, extracts and extends load data, and selects the result.
- Drives the register file write port (writeEnable, writeReg, writeData, nop) and the forwarding bus back to EX.
- Keeps a retired-instruction counter.

---
 rtl/writeback_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with load-data extraction and result select.
// Drives the register file write port, the EX forwarding bus and a retired-instruction counter.
module writeback_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             memValid,
    input  logic             memRegWrite,
    input  logic [4:0]       memRd,
    input  logic [1:0]       memWbSel,
    input  logic [2:0]       memFunct3,
    input  logic [XLEN-1:0]  memAluResult,
    input  logic [XLEN-1:0]  memReadData,
    input  logic [XLEN-1:0]  memPcPlus4,
    output logic             writeEnable,
    output logic [4:0]       writeReg,
    output logic [XLEN-1:0]  writeData,
    output logic             nop,
    output logic             fwdValid,
    output logic [4:0]       fwdReg,
    output logic [XLEN-1:0]  fwdData,
    output logic [CNT_W-1:0] retired
);

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic             valid_q,    valid_d;
    logic             regWrite_q, regWrite_d;
    logic [4:0]       rd_q,       rd_d;
    logic [1:0]       wbSel_q,    wbSel_d;
    logic [2:0]       funct3_q,   funct3_d;
    logic [XLEN-1:0]  alu_q,      alu_d;
    logic [XLEN-1:0]  rdata_q,    rdata_d;
    logic [XLEN-1:0]  pc4_q,      pc4_d;
    logic [CNT_W-1:0] retired_q,  retired_d;

    logic             retire;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [XLEN-1:0]  load_val;
    logic [XLEN-1:0]  result;

    // The WB instruction retires as it leaves: either it advances or it is flushed out.
    assign retire = valid_q & (~stall | flush);

    always_comb begin
        valid_d    = valid_q;
        regWrite_d = regWrite_q;
        rd_d       = rd_q;
        wbSel_d    = wbSel_q;
        funct3_d   = funct3_q;
        alu_d      = alu_q;
        rdata_d    = rdata_q;
        pc4_d      = pc4_q;
        retired_d  = retired_q;
        if (retire) begin
            retired_d = retired_q + CNT_W'(1);
        end
        if (flush) begin
            valid_d    = 1'b0;
            regWrite_d = 1'b0;
        end else if (!stall) begin
            valid_d    = memValid;
            regWrite_d = memRegWrite;
            rd_d       = memRd;
            wbSel_d    = memWbSel;
            funct3_d   = memFunct3;
            alu_d      = memAluResult;
            rdata_d    = memReadData;
            pc4_d      = memPcPlus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regWrite_q <= 1'b0;
            rd_q       <= 5'd0;
            wbSel_q    <= 2'b00;
            funct3_q   <= 3'b000;
            alu_q      <= '0;
            rdata_q    <= '0;
            pc4_q      <= '0;
            retired_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            regWrite_q <= regWrite_d;
            rd_q       <= rd_d;
            wbSel_q    <= wbSel_d;
            funct3_q   <= funct3_d;
            alu_q      <= alu_d;
            rdata_q    <= rdata_d;
            pc4_q      <= pc4_d;
            retired_q  <= retired_d;
        end
    end

    // Halfword lane uses alu_q[1] only; misaligned halves are not trapped.
    assign ld_byte = rdata_q[{alu_q[1:0], 3'b000} +: 8];
    assign ld_half = rdata_q[{alu_q[1], 4'b0000} +: 16];

    always_comb begin
        load_val = rdata_q;
        case (funct3_q)
            F3_LB:   load_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            F3_LH:   load_val = {{(XLEN-16){ld_half[15]}}, ld_half};
            F3_LBU:  load_val = {{(XLEN-8){1'b0}}, ld_byte};
            F3_LHU:  load_val = {{(XLEN-16){1'b0}}, ld_half};
            default: load_val = rdata_q;
        endcase
    end

    always_comb begin
        result = alu_q;
        case (wbSel_q)
            WB_ALU:  result = alu_q;
            WB_LOAD: result = load_val;
            WB_PC4:  result = pc4_q;
            default: result = alu_q;
        endcase
    end

    assign nop         = ~valid_q;
    assign writeEnable = valid_q & regWrite_q & (rd_q != 5'd0);
    assign writeReg    = rd_q;
    assign writeData   = result;
    assign fwdValid    = writeEnable;
    assign fwdReg      = writeReg;
    assign fwdData     = writeData;
    assign retired     = retired_q;

endmodule
